// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - command sequencer driving a 4-mode universal shift register
// Accepts READ/LOAD/SHL/SHR commands and returns register contents on a one-cycle strobe.

module uni_shift #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);
    logic [N-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            case (mode_i)
                2'b01:   q_q <= {q_q[N-2:0], d_i[0]};
                2'b10:   q_q <= {d_i[N-1], q_q[N-1:1]};
                2'b11:   q_q <= d_i;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;
endmodule

module shift_seq #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_op_i,
    input  logic [AW-1:0] cmd_amt_i,
    input  logic [1:0]    cmd_fill_i,
    input  logic [N-1:0]  cmd_data_i,
    output logic          rsp_valid_o,
    output logic [N-1:0]  rsp_data_o,
    output logic          busy_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;

    state_t        state_q;
    logic          dir_right_q;
    logic [1:0]    fill_q;
    logic [AW-1:0] cnt_q;
    logic [N-1:0]  data_q;
    logic [N-1:0]  shadow_q;
    logic          rsp_valid_q;
    logic          busy_q;
    logic          ready_q;

    logic [1:0]    mode_d;
    logic [N-1:0]  d_d;
    logic [N-1:0]  q_d;
    logic          fill_bit;
    logic [N-1:0]  q_w;

    // Fill comes from the shadow so the instance output never feeds its own inputs.
    always_comb begin
        fill_bit = 1'b0;
        case (fill_q)
            2'b00: fill_bit = 1'b0;
            2'b01: fill_bit = 1'b1;
            2'b10: fill_bit = dir_right_q ? shadow_q[0]   : shadow_q[N-1];
            2'b11: fill_bit = dir_right_q ? shadow_q[N-1] : shadow_q[0];
            default: fill_bit = 1'b0;
        endcase
    end

    always_comb begin
        mode_d = 2'b00;
        d_d    = '0;
        case (state_q)
            S_LOAD: begin
                mode_d = 2'b11;
                d_d    = data_q;
            end
            S_SHIFT: begin
                if (dir_right_q) begin
                    mode_d   = 2'b10;
                    d_d[N-1] = fill_bit;
                end else begin
                    mode_d = 2'b01;
                    d_d[0] = fill_bit;
                end
            end
            default: begin
                mode_d = 2'b00;
                d_d    = '0;
            end
        endcase
    end

    // Shadow applies the register's own next-state so it matches q in every cycle.
    always_comb begin
        q_d = shadow_q;
        case (mode_d)
            2'b01:   q_d = {shadow_q[N-2:0], d_d[0]};
            2'b10:   q_d = {d_d[N-1], shadow_q[N-1:1]};
            2'b11:   q_d = d_d;
            default: q_d = shadow_q;
        endcase
    end

    uni_shift #(.N(N)) u_reg (
        .clk    (clk),
        .rst    (rst),
        .mode_i (mode_d),
        .d_i    (d_d),
        .q_o    (q_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dir_right_q <= 1'b0;
            fill_q      <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            shadow_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            shadow_q    <= q_d;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid_i && ready_q) begin
                        dir_right_q <= cmd_op_i[0];
                        fill_q      <= cmd_fill_i;
                        data_q      <= cmd_data_i;
                        cnt_q       <= cmd_amt_i;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_op_i == OP_LOAD) begin
                            state_q <= S_LOAD;
                        end else if (cmd_op_i == OP_READ || cmd_amt_i == '0) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_LOAD: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                end
                S_SHIFT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == AW'(1)) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = q_w;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - directed scoreboard bench for shift_seq

module tb_shift_seq;
    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_amt = '0;
    logic [1:0]    cmd_fill = 2'b00;
    logic [N-1:0]  cmd_data = '0;
    logic          rsp_valid;
    logic [N-1:0]  rsp_data;
    logic          busy;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] exp_data_q[$];
    int           exp_lat_q[$];
    logic [N-1:0] model_v = '0;

    shift_seq #(.N(N), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_amt_i   (cmd_amt),
        .cmd_fill_i  (cmd_fill),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_shift(input logic [N-1:0] v, input logic right,
                                                 input logic [1:0] fill, input int amt);
        logic fb;
        for (int i = 0; i < amt; i++) begin
            case (fill)
                2'b00:   fb = 1'b0;
                2'b01:   fb = 1'b1;
                2'b10:   fb = right ? v[0] : v[N-1];
                default: fb = right ? v[N-1] : v[0];
            endcase
            v = right ? {fb, v[N-1:1]} : {v[N-2:0], fb};
        end
        return v;
    endfunction

    // Computes expectation, pushes it, and drives fields; caller must be at a negedge.
    task automatic drive_cmd(input logic [1:0] op, input int amt, input logic [1:0] fill,
                             input logic [N-1:0] data);
        int lat;
        case (op)
            2'b00: lat = 1;
            2'b01: begin model_v = data; lat = 2; end
            default: begin
                model_v = model_shift(model_v, op[0], fill, amt);
                lat = (amt == 0) ? 1 : 1 + amt;
            end
        endcase
        exp_data_q.push_back(model_v);
        exp_lat_q.push_back(lat);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = AW'(amt);
        cmd_fill  = fill;
        cmd_data  = data;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'b0, cmd_ready}, 32'd1);
    endtask

    // Leaves the bench at the negedge of the first cycle after acceptance, inputs scrambled.
    task automatic issue(input logic [1:0] op, input int amt, input logic [1:0] fill,
                         input logic [N-1:0] data);
        wait_ready();
        drive_cmd(op, amt, fill, data);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_amt   = AW'($urandom);
        cmd_fill  = 2'($urandom);
        cmd_data  = N'($urandom);
    endtask

    task automatic expect_rsp(input string tag);
        logic [N-1:0] ed;
        int el;
        int n = 1;
        int bad = 0;
        ed = exp_data_q.pop_front();
        el = exp_lat_q.pop_front();
        while (!rsp_valid && n < 40) begin
            if (!busy || cmd_ready) bad++;
            @(negedge clk);
            n++;
        end
        if (!busy || cmd_ready) bad++;
        check({tag, "_lat"}, n, el);
        check({tag, "_data"}, {24'b0, rsp_data}, {24'b0, ed});
        check({tag, "_busy_hs"}, bad, 0);
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_idle"}, {30'b0, busy, cmd_ready}, 32'd1);
    endtask

    initial begin
        int pulses;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rsp", {31'b0, rsp_valid}, 32'd0);
        check("rst_data", {24'b0, rsp_data}, 32'd0);
        rst = 1'b0;

        issue(2'b00, 0, 2'b00, 8'h5A);  expect_rsp("read0");
        issue(2'b01, 0, 2'b00, 8'hA5);  expect_rsp("load_a5");
        issue(2'b01, 0, 2'b00, 8'h81);  expect_rsp("load_81a");
        issue(2'b10, 3, 2'b00, 8'h00);  expect_rsp("shl3_zero");
        issue(2'b01, 0, 2'b00, 8'h81);  expect_rsp("load_81b");
        issue(2'b11, 3, 2'b01, 8'h00);  expect_rsp("shr3_one");
        issue(2'b01, 0, 2'b00, 8'h81);  expect_rsp("load_81c");
        issue(2'b10, 1, 2'b10, 8'h00);  expect_rsp("shl1_rot");
        issue(2'b01, 0, 2'b00, 8'h96);  expect_rsp("load_96");
        issue(2'b11, 9, 2'b10, 8'h00);  expect_rsp("shr9_rot");
        issue(2'b01, 0, 2'b00, 8'h80);  expect_rsp("load_80");
        issue(2'b11, 2, 2'b11, 8'h00);  expect_rsp("shr2_edge");
        issue(2'b10, 0, 2'b11, 8'h00);  expect_rsp("shl0");
        issue(2'b01, 0, 2'b00, 8'hFF);  expect_rsp("load_ff");
        issue(2'b10, 15, 2'b00, 8'h00); expect_rsp("shl15_zero");
        issue(2'b01, 0, 2'b00, 8'h6D);  expect_rsp("load_6d");
        issue(2'b10, 11, 2'b11, 8'h00); expect_rsp("shl11_edge");

        // Back-to-back with cmd_valid held and fields churning while busy.
        wait_ready();
        drive_cmd(2'b01, 0, 2'b00, 8'h3C);
        @(posedge clk);
        @(negedge clk);
        cmd_op   = 2'($urandom);
        cmd_amt  = AW'($urandom);
        cmd_fill = 2'($urandom);
        cmd_data = N'($urandom);
        expect_rsp("b2b_first");
        drive_cmd(2'b10, 1, 2'b00, 8'hEE);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        expect_rsp("b2b_second");

        // Reset in the middle of a long shift.
        issue(2'b01, 0, 2'b00, 8'hFF);  expect_rsp("load_ff2");
        issue(2'b10, 10, 2'b01, 8'h00);
        void'(exp_data_q.pop_back());
        void'(exp_lat_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rsp", {31'b0, rsp_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_ready", {31'b0, cmd_ready}, 32'd0);
        check("midrst_data", {24'b0, rsp_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_v = '0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("midrst_no_rsp", pulses, 0);
        check("midrst_ready_after", {31'b0, cmd_ready}, 32'd1);
        issue(2'b00, 0, 2'b00, 8'hFF);  expect_rsp("read_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
